// File: rtl/stage_mem.sv
// MEM pipeline stage: accepts one instruction at a time and runs loads/stores
// over a single-beat request/ack data bus. Results go out through registered WB outputs.
module stage_mem #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic [4:0]  rd,
   input  logic [31:0] alu_out_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] plusOffset_data,
   input  logic [31:0] imm,
   input  logic [31:0] plusFour_data,
   output logic        mem_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic [6:0]  wb_opcode,
   output logic        wb_mem_to_reg,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_plusOffset_data,
   output logic [31:0] wb_imm,
   output logic [31:0] wb_plusFour_data,
   output logic [31:0] wb_alu_out_data,
   output logic [31:0] wb_mem_data,
   output logic        mem_err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;
   // Counter only has to reach TIMEOUT-1: the expiring cycle is the last WAIT cycle.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;

   logic [2:0]    r_funct3;
   logic [1:0]    r_addr_lo;
   logic          r_is_store;
   logic [6:0]    r_opcode;
   logic          r_mem_to_reg;
   logic          r_reg_write;
   logic [4:0]    r_rd;
   logic [31:0]   r_alu;
   logic [31:0]   r_plusOffset;
   logic [31:0]   r_imm;
   logic [31:0]   r_plusFour;

   logic          r_dmem_req;
   logic          r_dmem_we;
   logic [31:0]   r_dmem_addr;
   logic [3:0]    r_dmem_be;
   logic [31:0]   r_dmem_wdata;

   logic          r_wb_valid;
   logic [6:0]    r_wb_opcode;
   logic          r_wb_mem_to_reg;
   logic          r_wb_reg_write;
   logic [4:0]    r_wb_rd;
   logic [31:0]   r_wb_plusOffset;
   logic [31:0]   r_wb_imm;
   logic [31:0]   r_wb_plusFour;
   logic [31:0]   r_wb_alu;
   logic [31:0]   r_wb_mem_data;
   logic          r_mem_err;

   logic          w_is_load;
   logic          w_is_store;
   logic          w_ld_ok;
   logic          w_st_ok;
   logic          w_misalign;
   logic          w_bad;
   logic          w_go;
   logic          w_timeout;
   logic [3:0]    w_st_be;
   logic [31:0]   w_st_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ld_data;

   assign w_is_load  = mem_read & ~mem_write;
   assign w_is_store = mem_write & ~mem_read;
   assign w_st_ok    = ~funct3[2] & (funct3[1:0] != 2'b11);
   assign w_misalign = ((funct3[1:0] == 2'b01) & alu_out_data[0])
                     | ((funct3[1:0] == 2'b10) & (alu_out_data[1:0] != 2'b00));
   assign w_bad      = (mem_read & mem_write)
                     | (w_is_load  & (~w_ld_ok | w_misalign))
                     | (w_is_store & (~w_st_ok | w_misalign));
   assign w_go       = (w_is_load | w_is_store) & ~w_bad;
   assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_ld_ok = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ld_ok = 1'b1;
         default:                                w_ld_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_st_be    = 4'hF;
      w_st_wdata = rs2_data;
      case (funct3[1:0])
         2'b00: begin
            w_st_be    = 4'b0001 << alu_out_data[1:0];
            w_st_wdata = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            w_st_be    = alu_out_data[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{rs2_data[15:0]}};
         end
         default: begin
            w_st_be    = 4'hF;
            w_st_wdata = rs2_data;
         end
      endcase
   end

   // Lane extraction uses the latched address/width, since upstream may change during WAIT.
   always_comb begin
      w_byte = dmem_rdata[7:0];
      case (r_addr_lo)
         2'd0:    w_byte = dmem_rdata[7:0];
         2'd1:    w_byte = dmem_rdata[15:8];
         2'd2:    w_byte = dmem_rdata[23:16];
         default: w_byte = dmem_rdata[31:24];
      endcase
      w_half    = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      w_ld_data = dmem_rdata;
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ld_data = {24'b0, w_byte};
         3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_ld_data = {16'b0, w_half};
         default: w_ld_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_cnt           <= '0;
         r_funct3        <= '0;
         r_addr_lo       <= '0;
         r_is_store      <= 1'b0;
         r_opcode        <= '0;
         r_mem_to_reg    <= 1'b0;
         r_reg_write     <= 1'b0;
         r_rd            <= '0;
         r_alu           <= '0;
         r_plusOffset    <= '0;
         r_imm           <= '0;
         r_plusFour      <= '0;
         r_dmem_req      <= 1'b0;
         r_dmem_we       <= 1'b0;
         r_dmem_addr     <= '0;
         r_dmem_be       <= '0;
         r_dmem_wdata    <= '0;
         r_wb_valid      <= 1'b0;
         r_wb_opcode     <= '0;
         r_wb_mem_to_reg <= 1'b0;
         r_wb_reg_write  <= 1'b0;
         r_wb_rd         <= '0;
         r_wb_plusOffset <= '0;
         r_wb_imm        <= '0;
         r_wb_plusFour   <= '0;
         r_wb_alu        <= '0;
         r_wb_mem_data   <= '0;
         r_mem_err       <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_mem_err  <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (in_valid) begin
               r_funct3     <= funct3;
               r_addr_lo    <= alu_out_data[1:0];
               r_is_store   <= w_is_store;
               r_opcode     <= opcode;
               r_mem_to_reg <= mem_to_reg;
               r_reg_write  <= reg_write;
               r_rd         <= rd;
               r_alu        <= alu_out_data;
               r_plusOffset <= plusOffset_data;
               r_imm        <= imm;
               r_plusFour   <= plusFour_data;
               if (w_go) begin
                  r_state      <= ST_WAIT;
                  r_cnt        <= '0;
                  r_dmem_req   <= 1'b1;
                  r_dmem_we    <= w_is_store;
                  r_dmem_addr  <= {alu_out_data[31:2], 2'b00};
                  r_dmem_be    <= w_is_store ? w_st_be : 4'hF;
                  r_dmem_wdata <= w_is_store ? w_st_wdata : 32'h0;
               end else begin
                  // Non-memory ops and rejected memory ops retire straight away.
                  r_wb_valid      <= 1'b1;
                  r_mem_err       <= w_bad;
                  r_wb_opcode     <= opcode;
                  r_wb_mem_to_reg <= mem_to_reg;
                  r_wb_reg_write  <= reg_write & ~w_bad;
                  r_wb_rd         <= rd;
                  r_wb_plusOffset <= plusOffset_data;
                  r_wb_imm        <= imm;
                  r_wb_plusFour   <= plusFour_data;
                  r_wb_alu        <= alu_out_data;
                  r_wb_mem_data   <= 32'h0;
               end
            end
         end else begin
            // An ack in the expiring cycle wins over the timeout.
            if (dmem_ack || w_timeout) begin
               r_state         <= ST_IDLE;
               r_dmem_req      <= 1'b0;
               r_dmem_we       <= 1'b0;
               r_dmem_be       <= 4'h0;
               r_wb_valid      <= 1'b1;
               r_mem_err       <= ~dmem_ack;
               r_wb_opcode     <= r_opcode;
               r_wb_mem_to_reg <= r_mem_to_reg;
               r_wb_reg_write  <= r_reg_write & ~r_is_store & dmem_ack;
               r_wb_rd         <= r_rd;
               r_wb_plusOffset <= r_plusOffset;
               r_wb_imm        <= r_imm;
               r_wb_plusFour   <= r_plusFour;
               r_wb_alu        <= r_alu;
               r_wb_mem_data   <= (dmem_ack & ~r_is_store) ? w_ld_data : 32'h0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign mem_stall          = (r_state == ST_WAIT);
   assign dmem_req           = r_dmem_req;
   assign dmem_we            = r_dmem_we;
   assign dmem_addr          = r_dmem_addr;
   assign dmem_be            = r_dmem_be;
   assign dmem_wdata         = r_dmem_wdata;
   assign wb_valid           = r_wb_valid;
   assign wb_opcode          = r_wb_opcode;
   assign wb_mem_to_reg      = r_wb_mem_to_reg;
   assign wb_reg_write       = r_wb_reg_write;
   assign wb_rd              = r_wb_rd;
   assign wb_plusOffset_data = r_wb_plusOffset;
   assign wb_imm             = r_wb_imm;
   assign wb_plusFour_data   = r_wb_plusFour;
   assign wb_alu_out_data    = r_wb_alu;
   assign wb_mem_data        = r_wb_mem_data;
   assign mem_err            = r_mem_err;

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles the block waits in WAIT for dmem_ack.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port list, upstream (EX/MEM) side:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- opcode  in  7  RISC-V opcode.
- funct3  in  3  load/store width code.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_to_reg  in  1  writeback select.
- reg_write  in  1  rd write enable.
- rd  in  5  destination register.
- alu_out_data  in  32  effective address / ALU result.
- rs2_data  in  32  store data.
- plusOffset_data  in  32  pc+imm.
- imm  in  32  immediate.
- plusFour_data  in  32  pc+4.
- mem_stall  out  1  upstream SHALL hold while high.
REQ-004 Port list, data bus side:
- dmem_req  out  1  bus request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address, bits [1:0]=0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  one-cycle completion strobe.
- dmem_rdata  in  32  read word, valid with ack.
REQ-005 Port list, WB-register side, all registered:
- wb_valid  out  1  WB outputs valid this cycle.
- wb_opcode  out  7  opcode to WB.
- wb_mem_to_reg  out  1  writeback select to WB.
- wb_reg_write  out  1  rd write enable to WB.
- wb_rd  out  5  destination register to WB.
- wb_plusOffset_data  out  32  pc+imm to WB.
- wb_imm  out  32  immediate to WB.
- wb_plusFour_data  out  32  pc+4 to WB.
- wb_alu_out_data  out  32  ALU result to WB.
- wb_mem_data  out  32  extended load data.
- mem_err  out  1  one-cycle fault flag, aligned with wb_valid.

Function
REQ-006 FSM states: IDLE and WAIT. An instruction is accepted only when in_valid=1 in IDLE; mem_stall SHALL equal (state==WAIT).
REQ-007 On accept, all upstream fields SHALL be latched internally, so upstream inputs are don't-care during WAIT.
REQ-008 For a non-memory op (mem_read=mem_write=0), the WB outputs SHALL load on the accept edge, with wb_valid=1 for exactly one cycle and wb_mem_data=0; latency is 1 cycle.
REQ-009 For a valid memory op, the block SHALL enter WAIT and raise dmem_req on the accept edge, holding dmem_req and all bus outputs stable until dmem_ack.
REQ-010 dmem_addr SHALL be {addr[31:2],2'b00}; loads SHALL drive dmem_we=0 and dmem_be=1111.
REQ-011 Stores SHALL drive bus lanes as follows:
- SB (000): be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
- SH (001): be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
- SW (010): be=1111, wdata=rs2.
REQ-012 Load extraction from dmem_rdata SHALL be:
- LB (000): byte at lane addr[1:0], sign-extended.
- LBU (100): byte at lane addr[1:0], zero-extended.
- LH (001): half at addr[1], sign-extended.
- LHU (101): half at addr[1], zero-extended.
- LW (010): full word.
REQ-013 On the edge where dmem_ack=1 in WAIT:
- dmem_req SHALL drop.
- WB outputs SHALL load with wb_valid=1 for one cycle.
- The state SHALL return to IDLE; the next accept is possible the following cycle.
REQ-014 Stores SHALL force wb_reg_write=0.
REQ-015 The following SHALL produce no bus request, and one cycle after accept drive wb_valid=1, mem_err=1 and wb_reg_write=0:
- Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- An illegal funct3: loads 011/110/111, stores other than 000/001/010.
- mem_read and mem_write both set.
REQ-016 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle without ack. When it reaches TIMEOUT, the block SHALL:
- drop dmem_req,
- complete with mem_err=1, wb_reg_write=0, wb_mem_data=0,
- return to IDLE.
REQ-017 dmem_ack SHALL be ignored in IDLE; an ack coinciding with the timeout cycle SHALL be treated as a normal completion.
REQ-018 wb_valid and mem_err SHALL be 0 in every cycle not specified above; the WB data outputs SHALL hold their last values.

Reset
REQ-019 When rst=1, the state SHALL go to IDLE and the counter to 0; every output SHALL be 0, including dmem_req, mem_stall, wb_valid and mem_err.
REQ-020 Reset asserted during WAIT SHALL abandon the request: dmem_req=0 on the next cycle, and an ack arriving after reset SHALL be ignored.

Verification
REQ-021 Loads: LB at addr 0x103 with rdata 0x80FF_1234 and ack after 3 cycles -> wb_mem_data=0xFFFF_FF80, wb_valid 1 cycle, mem_stall high for 3 cycles. Repeat as LBU -> 0x0000_0080.
REQ-022 Stores: SH at addr 0x202, rs2 0xDEAD_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, dmem_addr=0x200, wb_reg_write=0.
REQ-023 Misalignment: LW at addr 0x0006 -> dmem_req never asserted; next cycle wb_valid=1, mem_err=1, wb_reg_write=0.
REQ-024 Timeout: with TIMEOUT=4 and no ack -> dmem_req drops after 4 WAIT cycles; mem_err=1 and wb_valid=1 pulse; IDLE follows.
REQ-025 Reset and pass-through: rst during WAIT, then ack -> no wb_valid, all outputs 0. Back-to-back ALU ops (non-memory) -> wb_valid high every cycle with fields passed through.
